output_signature_compactor: RTL and testbench
=============================================

# output_signature_compactor

Consumes the wide output bus of an out-of-context design under test and compresses it into a multiple-input signature register (MISR). It is the output-side counterpart of the LFSR stimulus generators. It makes every DUT output bit observable, so implementation cannot prune logic, while exposing only a few top-level pins. Completed per-window signatures drain MSB-first over a 1-bit valid/ready serial port.

## Interface
- WIDTH, 64: width of the compacted data bus and of the signature; legal range ≥ 2.
- WINDOW, 256: number of accepted samples per signature window; legal range ≥ 1.
- TAPS, 64'hD800_0000_0000_0000: MISR feedback mask (bit i set = misr[i] feeds back); WIDTH bits.
- SEED, 0: MISR value at reset and at the start of each window; WIDTH bits.

- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- data_in  in  WIDTH  DUT output word to compact.
- data_valid  in  1  data_in is sampled on this edge when 1.
- sig_bit  out  1  current serial signature bit, MSB first.
- sig_valid  out  1  sig_bit holds a valid signature bit.
- sig_ready  in  1  consumer accepts sig_bit when sig_valid & sig_ready.
- sig_last  out  1  high with sig_valid on bit 0 (the last bit) of a signature.
- window_done  out  1  one-cycle pulse: a window just closed.
- overrun  out  1  sticky: a completed signature was dropped.

## Operation
- Registers:
  - misr[WIDTH]
  - sample count cnt (width $clog2(WINDOW+1))
  - shift register sh[WIDTH]
  - bit index idx
  - drain state
- MISR update on an accepted sample (data_valid=1):
  - fb = ^(misr & TAPS)
  - next = ({misr[WIDTH-2:0], fb}) ^ data_in
  - All arithmetic is truncated to WIDTH bits.
- Window close: the sample that makes cnt reach WINDOW closes the window.
  - The window's signature is the next value computed from that sample.
  - On the same edge: misr <= SEED, cnt <= 0, window_done pulses next cycle.
- data_valid=0: misr and cnt hold.
- Accumulation never stalls; a new window starts immediately, including while a drain is in progress.
- FSM, two states:
  - IDLE: sig_valid=0. On window close, sh <= signature, idx <= WIDTH-1, go to DRAIN.
  - DRAIN: sig_valid=1, sig_bit=sh[WIDTH-1], sig_last=(idx==0).
    - On a transfer with idx≠0: sh shifts left by 1, idx decrements.
    - On a transfer with idx==0: return to IDLE.
- Simultaneous events:
  - Window close while in DRAIN with no final-bit transfer that edge: the signature is dropped, overrun <= 1, and the in-flight drain continues unchanged.
  - Window close on the same edge as the final-bit transfer: not an overrun. The new signature loads, the FSM stays in DRAIN, and sig_valid stays 1.
- overrun clears only on reset.
- Reset mid-operation (asynchronous): all state returns to reset values immediately, and any partial window or drain is discarded.

## Timing
- Reset values:
  - misr = SEED, cnt = 0, IDLE
  - sig_bit = 0, sig_valid = 0, sig_last = 0
  - window_done = 0, overrun = 0
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Latency: on edge E (window-closing sample), sig_valid and window_done are 1 in the cycle after E, with sig_bit = signature MSB.
- A signature needs ≥ WIDTH cycles to drain (exactly WIDTH with sig_ready held at 1).
- sig_bit, sig_last and sig_valid are stable while sig_valid=1 and sig_ready=0.
- sig_ready is ignored while sig_valid=0.
- With WINDOW ≥ WIDTH and continuous sig_ready, overrun never occurs.

## Test plan
All scenarios use bench parameters WIDTH=8, WINDOW=4, TAPS=8'hB8, SEED=0.
- Reset: hold reset=0 for 3 cycles with random inputs -> all outputs 0; after release, with data_valid=0 for 20 cycles, sig_valid stays 0.
- Single-bit injection: samples 01,00,00,00 with data_valid=1 and sig_ready=1 ->
  - window_done pulses once, in the cycle after the 4th sample.
  - Serial bits are 0,0,0,0,1,0,0,0 (0x08).
  - sig_last is high on the 8th bit only.
- Feedback path: samples 80,00,00,00 -> signature 0x04. Then a gapped stream 80,(invalid×3),00,00,00 -> same 0x04, showing data_valid gating.
- Backpressure: sig_ready toggled 1,0,0,1,... during a drain of 0x08 -> bits unchanged while stalled, exactly 8 transfers, then sig_valid=0.
- Back-to-back windows: continuous samples with sig_ready=0 until the second window closes -> overrun=1, first signature still drains intact. Repeat with sig_ready=1 throughout -> overrun stays 0.
- Reset mid-drain: assert reset after 3 bits are transferred -> sig_valid drops immediately. The next window of 01,00,00,00 yields 0x08.

Source files
------------

// File: rtl/output_signature_compactor.sv
// output_signature_compactor: MISR compaction of a wide DUT output bus, with
// each per-window signature drained MSB-first over a 1-bit valid/ready port.
module output_signature_compactor #(
   parameter int               WIDTH  = 64,
   parameter int               WINDOW = 256,
   parameter logic [WIDTH-1:0] TAPS   = 64'hD800_0000_0000_0000,
   parameter logic [WIDTH-1:0] SEED   = '0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] data_in_i,
   input  logic             data_valid_i,
   output logic             sig_bit_o,
   output logic             sig_valid_o,
   input  logic             sig_ready_i,
   output logic             sig_last_o,
   output logic             window_done_o,
   output logic             overrun_o
);
   localparam int CW = $clog2(WINDOW + 1);
   localparam int IW = $clog2(WIDTH);
   typedef enum logic {IDLE, DRAIN} state_t;
   state_t           state_q;
   logic [WIDTH-1:0] misr_q, misr_d, sh_q;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [IW-1:0]    idx_q;
   logic             done_q, ovr_q, fb, close, xfer, fin;
   always_comb begin
      fb     = ^(misr_q & TAPS);
      misr_d = data_valid_i ? ({misr_q[WIDTH-2:0], fb} ^ data_in_i) : misr_q;
      cnt_d  = data_valid_i ? cnt_q + 1'b1 : cnt_q;
      close  = data_valid_i && (cnt_q == CW'(WINDOW - 1));
      xfer   = (state_q == DRAIN) && sig_ready_i;
      fin    = xfer && (idx_q == '0);
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         misr_q  <= SEED;
         cnt_q   <= '0;
         sh_q    <= '0;
         idx_q   <= '0;
         done_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         misr_q <= close ? SEED : misr_d;
         cnt_q  <= close ? '0 : cnt_d;
         done_q <= close;
         // a closing window can only be accepted when the drain port is free this edge
         if (close && (state_q == DRAIN) && !fin) ovr_q <= 1'b1;
         if (close && ((state_q == IDLE) || fin)) begin
            sh_q    <= misr_d;
            idx_q   <= IW'(WIDTH - 1);
            state_q <= DRAIN;
         end else if (fin) begin
            sh_q    <= '0;
            state_q <= IDLE;
         end else if (xfer) begin
            sh_q  <= {sh_q[WIDTH-2:0], 1'b0};
            idx_q <= idx_q - 1'b1;
         end
      end
   end
   assign sig_valid_o   = (state_q == DRAIN);
   assign sig_bit_o     = sh_q[WIDTH-1];
   assign sig_last_o    = (state_q == DRAIN) && (idx_q == '0);
   assign window_done_o = done_q;
   assign overrun_o     = ovr_q;
endmodule

// File: tb/tb_output_signature_compactor.sv
// tb_output_signature_compactor: directed scenarios for the MISR signature compactor.
module tb_output_signature_compactor;
   logic       clk = 1'b0;
   logic       rst_ni = 1'b1;
   logic [7:0] data_in = '0;
   logic       data_valid = 1'b0;
   logic       sig_ready = 1'b0;
   logic       sig_bit, sig_valid, sig_last, window_done, overrun;
   int         n_cmp = 0;
   int         n_bad = 0;

   output_signature_compactor #(.WIDTH(8), .WINDOW(4), .TAPS(8'hB8), .SEED(8'h00)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .data_in_i(data_in), .data_valid_i(data_valid),
      .sig_bit_o(sig_bit), .sig_valid_o(sig_valid), .sig_ready_i(sig_ready),
      .sig_last_o(sig_last), .window_done_o(window_done), .overrun_o(overrun)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d);
      data_valid = 1'b1;
      data_in    = d;
      step();
      data_valid = 1'b0;
      data_in    = '0;
   endtask

   task automatic drain_expect(input logic [7:0] exp, input string nm);
      logic [7:0] got = '0;
      sig_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         n_cmp++;
         if (sig_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL %s valid bit%0d: got %b expected 1", nm, i, sig_valid);
         end
         n_cmp++;
         if (sig_last !== (i == 7)) begin
            n_bad++;
            $display("FAIL %s last bit%0d: got %b expected %b", nm, i, sig_last, i == 7);
         end
         got[7-i] = sig_bit;
         step();
      end
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s signature: got %h expected %h", nm, got, exp);
      end
      n_cmp++;
      if (sig_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL %s valid after drain: got %b expected 0", nm, sig_valid);
      end
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      for (int i = 0; i < 3; i++) begin
         data_in    = 8'($urandom);
         data_valid = 1'($urandom);
         sig_ready  = 1'($urandom);
         step();
      end
      n_cmp++;
      if ({sig_bit, sig_valid, sig_last, window_done, overrun} !== 5'b0) begin
         n_bad++;
         $display("FAIL reset outputs: got %b expected 00000",
                  {sig_bit, sig_valid, sig_last, window_done, overrun});
      end
      data_valid = 1'b0;
      data_in    = '0;
      sig_ready  = 1'b0;
      rst_ni     = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         n_cmp++;
         if (sig_valid !== 1'b0 || window_done !== 1'b0) begin
            n_bad++;
            $display("FAIL idle after reset cycle %0d: got valid=%b done=%b expected 0 0",
                     i, sig_valid, window_done);
         end
      end
   endtask

   task automatic test_single_bit();
      sig_ready = 1'b1;
      send(8'h01);
      send(8'h00);
      send(8'h00);
      n_cmp++;
      if (window_done !== 1'b0) begin
         n_bad++;
         $display("FAIL single early done: got %b expected 0", window_done);
      end
      send(8'h00);
      n_cmp++;
      if (window_done !== 1'b1) begin
         n_bad++;
         $display("FAIL single done pulse: got %b expected 1", window_done);
      end
      drain_expect(8'h08, "single");
      n_cmp++;
      if (window_done !== 1'b0) begin
         n_bad++;
         $display("FAIL single done after: got %b expected 0", window_done);
      end
   endtask

   task automatic test_feedback();
      send(8'h80);
      send(8'h00);
      send(8'h00);
      send(8'h00);
      drain_expect(8'h04, "feedback");
      send(8'h80);
      for (int i = 0; i < 3; i++) step();
      send(8'h00);
      send(8'h00);
      n_cmp++;
      if (sig_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL gapped early close: got valid %b expected 0", sig_valid);
      end
      send(8'h00);
      drain_expect(8'h04, "gapped");
   endtask

   task automatic test_backpressure();
      logic [3:0] pat = 4'b1001;
      logic [7:0] exp = 8'h08;
      int         n = 0;
      sig_ready = 1'b1;
      send(8'h01);
      send(8'h00);
      send(8'h00);
      send(8'h00);
      for (int c = 0; c < 64 && n < 8; c++) begin
         sig_ready = pat[3 - (c % 4)];
         n_cmp++;
         if (sig_valid !== 1'b1 || sig_bit !== exp[7-n] || sig_last !== (n == 7)) begin
            n_bad++;
            $display("FAIL backpressure cycle %0d bit%0d: got v=%b b=%b l=%b expected 1 %b %b",
                     c, n, sig_valid, sig_bit, sig_last, exp[7-n], n == 7);
         end
         if (sig_ready) n++;
         step();
      end
      n_cmp++;
      if (n !== 8 || sig_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL backpressure end: got %0d transfers valid=%b expected 8 valid=0", n, sig_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] bits = '0;
      sig_ready = 1'b0;
      send(8'h01);
      send(8'h00);
      send(8'h00);
      send(8'h00);
      n_cmp++;
      if (overrun !== 1'b0) begin
         n_bad++;
         $display("FAIL b2b early overrun: got %b expected 0", overrun);
      end
      send(8'h80);
      send(8'h00);
      send(8'h00);
      send(8'h00);
      n_cmp++;
      if (overrun !== 1'b1 || window_done !== 1'b1) begin
         n_bad++;
         $display("FAIL b2b overrun: got ovr=%b done=%b expected 1 1", overrun, window_done);
      end
      drain_expect(8'h08, "b2b first");
      rst_ni = 1'b0;
      #1;
      rst_ni = 1'b1;
      sig_ready = 1'b1;
      send(8'h01);
      send(8'h00);
      send(8'h00);
      send(8'h00);
      // second window closes on the same edge as the final bit of the first
      for (int k = 0; k < 16; k++) begin
         data_valid = (k >= 4 && k < 8);
         data_in    = (k == 4) ? 8'h80 : 8'h00;
         n_cmp++;
         if (sig_valid !== 1'b1 || sig_last !== (k == 7 || k == 15)) begin
            n_bad++;
            $display("FAIL chained cycle %0d: got v=%b l=%b expected 1 %b",
                     k, sig_valid, sig_last, k == 7 || k == 15);
         end
         bits = {bits[14:0], sig_bit};
         step();
      end
      data_valid = 1'b0;
      n_cmp++;
      if (bits !== 16'h0804 || overrun !== 1'b0 || sig_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL chained end: got bits=%h ovr=%b v=%b expected 0804 0 0", bits, overrun, sig_valid);
      end
   endtask

   task automatic test_reset_mid_drain();
      sig_ready = 1'b1;
      send(8'h01);
      send(8'h00);
      send(8'h00);
      send(8'h00);
      send(8'h01);
      send(8'h00);
      step();
      rst_ni = 1'b0;
      #1;
      n_cmp++;
      if (sig_valid !== 1'b0 || sig_bit !== 1'b0 || overrun !== 1'b0) begin
         n_bad++;
         $display("FAIL mid-drain reset: got v=%b b=%b ovr=%b expected 0 0 0", sig_valid, sig_bit, overrun);
      end
      #2;
      rst_ni = 1'b1;
      step();
      send(8'h01);
      send(8'h00);
      send(8'h00);
      n_cmp++;
      if (sig_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL partial window kept across reset: got valid %b expected 0", sig_valid);
      end
      send(8'h00);
      drain_expect(8'h08, "after reset");
   endtask

   initial begin
      test_reset();
      test_single_bit();
      test_feedback();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
